debug_mem_sequencer: RTL and testbench
======================================

Name: debug_mem_sequencer

Overview:
Hardware replacement for the bench-driven load/run/dump flow of the RV32I core.
- Streams a host image into the DataCache, then the InstCache, through the debug port 2 (A2/WD2/WE2/RD2).
- Pulses core reset and lets the core run for a fixed cycle budget.
- Reads back both caches word by word onto a dump stream.
- Sits between a host link (UART/JTAG bridge) and the RV32ICore debug ports.

Parameters:
BRAMWORDS, 4096, words per cache (32-bit words)
RUN_CYCLES, 200000, CPU_CLK cycles the core runs after reset release
RST_CYCLES, 4, cycles core_rst is held high between load and run
RD_LATENCY, 1, BRAM port-2 read latency in cycles (1..3)

Ports:
CPU_CLK  in  1  clock
CPU_RST  in  1  reset, asynchronous, active-high
start  in  1  pulse; begins a sequence from IDLE or DONE
ld_valid  in  1  load beat valid
ld_data  in  32  load word
ld_last  in  1  last word of the current cache image
ld_ready  out  1  load beat accepted when ld_valid&ld_ready
dp_valid  out  1  dump beat valid
dp_addr  out  32  byte address of the dump word
dp_data  out  32  dump word
dp_sel  out  1  dump source: 0=DataCache, 1=InstCache
dp_ready  in  1  dump consumer ready
core_rst  out  1  drives RV32ICore CPU_RST
Dbg_DataCache_A2  out  32  DataCache port-2 address
Dbg_DataCache_WD2  out  32  DataCache port-2 write data
Dbg_DataCache_WE2  out  4  DataCache port-2 byte enables
Dbg_DataCache_RD2  in  32  DataCache port-2 read data
Dbg_InstCache_A2 / WD2 / WE2 / RD2  same as the DataCache set, for the InstCache
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset values: state=IDLE, core_rst=1, all A2/WD2=0, WE2=0, ld_ready=0, dp_valid=0, dp_addr=0, dp_data=0, dp_sel=0, busy=0, done=0.
- States: IDLE -> LOAD_D -> LOAD_I -> CRST -> RUN -> DUMP_D -> DUMP_I -> DONE.
  - start takes IDLE->LOAD_D and DONE->LOAD_D.
  - start is ignored in all other states.
- LOAD_D / LOAD_I:
  - ld_ready=1. Word counter wcnt starts at 0.
  - Each accepted beat drives A2=wcnt*4, WD2=ld_data, WE2=4'b1111 for exactly that cycle, then wcnt increments.
  - WE2=0 on every non-accept cycle.
  - Phase ends after the beat with ld_last=1 or wcnt==BRAMWORDS-1; wcnt clears at the phase change.
  - Words beyond the image are not written.
  - ld_ready=0 in all other states; beats offered there are not consumed.
- CRST: core_rst=1 for RST_CYCLES cycles, then -> RUN.
- core_rst=1 in IDLE, LOAD_*, CRST and DONE; core_rst=0 only in RUN and DUMP_*.
- RUN: down-counter loaded with RUN_CYCLES-1; -> DUMP_D on reaching 0. Debug ports are idle, with WE2=0.
- DUMP_D / DUMP_I, per word:
  - Drive A2=wcnt*4 and wait RD_LATENCY cycles.
  - Register RD2 into dp_data, set dp_addr=wcnt*4 and dp_sel, raise dp_valid.
  - Hold dp_valid, dp_addr, dp_data and dp_sel stable until dp_ready.
  - On the handshake: dp_valid drops the next cycle and wcnt increments.
- Dump always covers all BRAMWORDS words. After word BRAMWORDS-1 of DUMP_D -> DUMP_I (wcnt=0); after its last word -> DONE.
- WE2 is never asserted during DUMP or RUN.
- Width: wcnt is clog2(BRAMWORDS) bits with no wrap past BRAMWORDS-1. Addresses are zero-extended to 32 bits with [1:0]=0.
- ld_last on the very first beat is a legal 1-word image.
- CPU_RST mid-operation: immediate return to reset values. Partially written BRAM content is not undone.

Decomposition:
- Shared package:
  - state encoding enum.
  - WE_ALL=4'b1111 and WE_NONE constants.
  - Cache-select encoding (SEL_DATA=0, SEL_INST=1).
- One sub-module, dbg_port_mux: steers a single internal A/WD/WE/RD channel to the DataCache or InstCache port set by select. The non-selected port gets WE2=0 and A2=0.

Test Plan:
- Reset released, no start -> core_rst=1, busy=0, all WE2=0 for 100 cycles.
- start; 3 data words {11,22,33}, last on the 3rd; 2 inst words {13,93} -> DataCache writes at 0x0/0x4/0x8 and InstCache writes at 0x0/0x4, each WE2=1111 for one cycle; then core_rst high for exactly 4 cycles.
- RUN_CYCLES=10 -> core_rst low for 10 cycles before the first dump address appears.
- Dump with BRAMWORDS=8, RD_LATENCY=2, dp_ready low 5 cycles on word 3 -> dp_valid/dp_data held stable; 16 beats total, dp_sel switches at beat 8, addresses 0x0..0x1C twice; then done=1.
- ld_valid held high during RUN -> ld_ready=0 and no BRAM write.
- CPU_RST asserted mid-LOAD_I -> next cycle state IDLE, WE2=0, core_rst=1; a new start reloads from address 0.

Source files
------------

// File: rtl/debug_mem_sequencer_pkg.sv
// debug_mem_sequencer_pkg: shared state encoding, byte-enable and cache-select constants
package debug_mem_sequencer_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_D, S_LOAD_I, S_CRST, S_RUN, S_DUMP_D, S_DUMP_I, S_DONE
    } state_e;
    localparam logic [3:0] WE_ALL   = 4'b1111;
    localparam logic [3:0] WE_NONE  = 4'b0000;
    localparam logic       SEL_DATA = 1'b0;
    localparam logic       SEL_INST = 1'b1;
endpackage

// File: rtl/debug_mem_sequencer_dbg_port_mux.sv
// dbg_port_mux: steers one debug channel to the DataCache or InstCache port-2 set
module dbg_port_mux
    import debug_mem_sequencer_pkg::*;
(
    input  logic        sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] wd_i,
    input  logic [3:0]  we_i,
    output logic [31:0] rd_o,
    output logic [31:0] dc_a_o,
    output logic [31:0] dc_wd_o,
    output logic [3:0]  dc_we_o,
    input  logic [31:0] dc_rd_i,
    output logic [31:0] ic_a_o,
    output logic [31:0] ic_wd_o,
    output logic [3:0]  ic_we_o,
    input  logic [31:0] ic_rd_i
);
    logic is_inst;
    assign is_inst = sel_i == SEL_INST;
    assign dc_a_o  = is_inst ? '0 : a_i;
    assign dc_wd_o = is_inst ? '0 : wd_i;
    assign dc_we_o = is_inst ? WE_NONE : we_i;
    assign ic_a_o  = is_inst ? a_i : '0;
    assign ic_wd_o = is_inst ? wd_i : '0;
    assign ic_we_o = is_inst ? we_i : WE_NONE;
    assign rd_o    = is_inst ? ic_rd_i : dc_rd_i;
endmodule

// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer: loads both caches from a host stream, resets and runs the core,
// then dumps both caches word by word onto a valid/ready stream
module debug_mem_sequencer
    import debug_mem_sequencer_pkg::*;
#(
    parameter int BRAMWORDS  = 4096,
    parameter int RUN_CYCLES = 200000,
    parameter int RST_CYCLES = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        dp_valid,
    output logic [31:0] dp_addr,
    output logic [31:0] dp_data,
    output logic        dp_sel,
    input  logic        dp_ready,
    output logic        core_rst,
    output logic [31:0] Dbg_DataCache_A2,
    output logic [31:0] Dbg_DataCache_WD2,
    output logic [3:0]  Dbg_DataCache_WE2,
    input  logic [31:0] Dbg_DataCache_RD2,
    output logic [31:0] Dbg_InstCache_A2,
    output logic [31:0] Dbg_InstCache_WD2,
    output logic [3:0]  Dbg_InstCache_WE2,
    input  logic [31:0] Dbg_InstCache_RD2,
    output logic        busy,
    output logic        done
);
    localparam int AW = (BRAMWORDS > 1) ? $clog2(BRAMWORDS) : 1;

    state_e        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          dp_valid_q, dp_valid_d, dp_sel_q, dp_sel_d;
    logic [31:0]   dp_addr_q, dp_addr_d, dp_data_q, dp_data_d;
    logic          loading, dumping, accept, last_word, sel;
    logic [31:0]   addr, rd;

    assign loading   = state_q == S_LOAD_D || state_q == S_LOAD_I;
    assign dumping   = state_q == S_DUMP_D || state_q == S_DUMP_I;
    assign accept    = loading && ld_valid;
    assign last_word = wcnt_q == AW'(BRAMWORDS - 1);
    assign sel       = (state_q == S_LOAD_I || state_q == S_DUMP_I) ? SEL_INST : SEL_DATA;
    assign addr      = {{(30 - AW){1'b0}}, wcnt_q, 2'b00};

    assign ld_ready = loading;
    assign core_rst = !(state_q == S_RUN || dumping);
    assign busy     = !(state_q == S_IDLE || state_q == S_DONE);
    assign done     = state_q == S_DONE;
    assign dp_valid = dp_valid_q;
    assign dp_addr  = dp_addr_q;
    assign dp_data  = dp_data_q;
    assign dp_sel   = dp_sel_q;

    dbg_port_mux u_mux (
        .sel_i  (sel),
        .a_i    ((loading || dumping) ? addr : 32'd0),
        .wd_i   (accept ? ld_data : 32'd0),
        .we_i   (accept ? WE_ALL : WE_NONE),
        .rd_o   (rd),
        .dc_a_o (Dbg_DataCache_A2),
        .dc_wd_o(Dbg_DataCache_WD2),
        .dc_we_o(Dbg_DataCache_WE2),
        .dc_rd_i(Dbg_DataCache_RD2),
        .ic_a_o (Dbg_InstCache_A2),
        .ic_wd_o(Dbg_InstCache_WD2),
        .ic_we_o(Dbg_InstCache_WE2),
        .ic_rd_i(Dbg_InstCache_RD2)
    );

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_addr_d  = dp_addr_q;
        dp_data_d  = dp_data_q;
        dp_sel_d   = dp_sel_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_LOAD_D;
                wcnt_d  = '0;
            end
            S_LOAD_D, S_LOAD_I: if (accept) begin
                wcnt_d = wcnt_q + 1'b1;
                if (ld_last || last_word) begin
                    wcnt_d  = '0;
                    cnt_d   = 32'(RST_CYCLES - 1);
                    state_d = (state_q == S_LOAD_D) ? S_LOAD_I : S_CRST;
                end
            end
            S_CRST: if (cnt_q == 32'd0) begin
                state_d = S_RUN;
                cnt_d   = 32'(RUN_CYCLES - 1);
            end else cnt_d = cnt_q - 32'd1;
            S_RUN: if (cnt_q == 32'd0) begin
                state_d = S_DUMP_D;
                cnt_d   = 32'd0;
            end else cnt_d = cnt_q - 32'd1;
            // cnt_q counts cycles since the current word's address was presented
            S_DUMP_D, S_DUMP_I: if (dp_valid_q) begin
                if (dp_ready) begin
                    dp_valid_d = 1'b0;
                    cnt_d      = 32'd0;
                    wcnt_d     = wcnt_q + 1'b1;
                    if (last_word) begin
                        wcnt_d  = '0;
                        state_d = (state_q == S_DUMP_D) ? S_DUMP_I : S_DONE;
                    end
                end
            end else if (cnt_q == 32'(RD_LATENCY)) begin
                dp_valid_d = 1'b1;
                dp_data_d  = rd;
                dp_addr_d  = addr;
                dp_sel_d   = sel;
            end else cnt_d = cnt_q + 32'd1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_data_q  <= '0;
            dp_sel_q   <= SEL_DATA;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_addr_q  <= dp_addr_d;
            dp_data_q  <= dp_data_d;
            dp_sel_q   <= dp_sel_d;
        end
    end
endmodule

// File: tb/tb_debug_mem_sequencer.sv
// tb_debug_mem_sequencer: directed checks of load, reset pulse, run budget, dump and mid-run reset
module tb_debug_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, ld_valid, ld_last, ld_ready, dp_valid, dp_sel, dp_ready;
    logic        core_rst, busy, done;
    logic [31:0] ld_data, dp_addr, dp_data;
    logic [31:0] dc_a, dc_wd, dc_rd, ic_a, ic_wd, ic_rd, dc_p, ic_p;
    logic [3:0]  dc_we, ic_we;
    int          total = 0, bad = 0;

    logic [31:0] dmem [8] = '{32'hD0000000, 32'hD0000001, 32'hD0000002, 32'hD0000003,
                              32'hD0000004, 32'hD0000005, 32'hD0000006, 32'hD0000007};
    logic [31:0] imem [8] = '{32'hE0000000, 32'hE0000001, 32'hE0000002, 32'hE0000003,
                              32'hE0000004, 32'hE0000005, 32'hE0000006, 32'hE0000007};
    logic [31:0] exp_dump [16] = '{32'd11, 32'd22, 32'd33, 32'hD0000003,
                                   32'hD0000004, 32'hD0000005, 32'hD0000006, 32'hD0000007,
                                   32'd13, 32'd93, 32'hE0000002, 32'hE0000003,
                                   32'hE0000004, 32'hE0000005, 32'hE0000006, 32'hE0000007};

    always #5 clk = ~clk;

    // two-cycle-latency BRAM stubs for port 2 of each cache
    always @(posedge clk) begin
        if (dc_we == 4'hF) dmem[dc_a[4:2]] <= dc_wd;
        if (ic_we == 4'hF) imem[ic_a[4:2]] <= ic_wd;
        dc_p  <= dmem[dc_a[4:2]];
        ic_p  <= imem[ic_a[4:2]];
        dc_rd <= dc_p;
        ic_rd <= ic_p;
    end

    debug_mem_sequencer #(.BRAMWORDS(8), .RUN_CYCLES(10), .RST_CYCLES(4), .RD_LATENCY(2)) dut (
        .CPU_CLK(clk), .CPU_RST(rst), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .dp_valid(dp_valid), .dp_addr(dp_addr), .dp_data(dp_data), .dp_sel(dp_sel),
        .dp_ready(dp_ready), .core_rst(core_rst),
        .Dbg_DataCache_A2(dc_a), .Dbg_DataCache_WD2(dc_wd), .Dbg_DataCache_WE2(dc_we),
        .Dbg_DataCache_RD2(dc_rd),
        .Dbg_InstCache_A2(ic_a), .Dbg_InstCache_WD2(ic_wd), .Dbg_InstCache_WE2(ic_we),
        .Dbg_InstCache_RD2(ic_rd),
        .busy(busy), .done(done)
    );

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; dp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({core_rst, busy, done, ld_ready, dp_valid, dp_sel} !== 6'b100000)
            begin bad++; $display("FAIL reset_flags got=%b want=100000", {core_rst, busy, done, ld_ready, dp_valid, dp_sel}); end
        total++;
        if (dp_addr !== 0 || dp_data !== 0 || dc_a !== 0 || ic_a !== 0 || dc_wd !== 0 || ic_wd !== 0)
            begin bad++; $display("FAIL reset_words got addr=%h data=%h dca=%h ica=%h want 0", dp_addr, dp_data, dc_a, ic_a); end
        @(negedge clk); rst = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            total++;
            if (core_rst !== 1'b1 || busy !== 1'b0 || dc_we !== 0 || ic_we !== 0 || ld_ready !== 1'b0)
                begin bad++; $display("FAIL idle_cycle%0d got rst=%b busy=%b we=%h/%h rdy=%b want 1 0 0/0 0", i, core_rst, busy, dc_we, ic_we, ld_ready); end
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_load;
        logic [31:0] dw [3] = '{32'd11, 32'd22, 32'd33};
        logic [31:0] iw [2] = '{32'd13, 32'd93};
        int n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        total++;
        if (ld_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL load_ready got rdy=%b busy=%b want 1 1", ld_ready, busy); end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = dw[i]; ld_last = (i == 2); #1;
            total++;
            if (dc_we !== 4'hF || dc_a !== 32'(i * 4) || dc_wd !== dw[i] || ic_we !== 0 || ic_a !== 0)
                begin bad++; $display("FAIL load_d%0d got we=%h a=%h wd=%h iwe=%h ia=%h want F %h %h 0 0", i, dc_we, dc_a, dc_wd, ic_we, ic_a, i * 4, dw[i]); end
            @(negedge clk);
            if (i == 1) begin
                ld_valid = 1'b0; #1;
                total++;
                if (dc_we !== 0 || ic_we !== 0) begin bad++; $display("FAIL load_gap got we=%h/%h want 0/0", dc_we, ic_we); end
                @(negedge clk);
            end
        end
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = iw[i]; ld_last = (i == 1); #1;
            total++;
            if (ic_we !== 4'hF || ic_a !== 32'(i * 4) || ic_wd !== iw[i] || dc_we !== 0 || dc_a !== 0)
                begin bad++; $display("FAIL load_i%0d got we=%h a=%h wd=%h dwe=%h da=%h want F %h %h 0 0", i, ic_we, ic_a, ic_wd, dc_we, dc_a, i * 4, iw[i]); end
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!core_rst) break;
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 4) begin bad++; $display("FAIL crst_len got=%0d want=4", n); end
    endtask

    task automatic test_run;
        int n = 0;
        // RUN is 10 cycles, then 3 cycles of read latency before word 0 is valid
        for (int k = 0; k < 40; k++) begin
            ld_valid = 1'b1; #1;
            if (dp_valid) break;
            total++;
            if (core_rst !== 1'b0 || ld_ready !== 1'b0 || dc_we !== 0 || ic_we !== 0)
                begin bad++; $display("FAIL run_cycle%0d got rst=%b rdy=%b we=%h/%h want 0 0 0/0", k, core_rst, ld_ready, dc_we, ic_we); end
            n++;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        total++;
        if (n !== 13) begin bad++; $display("FAIL run_len got=%0d want=13", n); end
    endtask

    task automatic test_dump;
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 20 && !dp_valid; k++) begin @(negedge clk); #1; end
            total++;
            if (dp_valid !== 1'b1 || dp_addr !== 32'((b % 8) * 4) || dp_data !== exp_dump[b] || dp_sel !== (b >= 8))
                begin bad++; $display("FAIL dump%0d got v=%b a=%h d=%h s=%b want 1 %h %h %b", b, dp_valid, dp_addr, dp_data, dp_sel, (b % 8) * 4, exp_dump[b], b >= 8); end
            if (b == 3) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    total++;
                    if (dp_valid !== 1'b1 || dp_data !== exp_dump[3] || dp_addr !== 32'hC || dp_sel !== 1'b0 || dc_we !== 0)
                        begin bad++; $display("FAIL stall%0d got v=%b a=%h d=%h want 1 c %h", k, dp_valid, dp_addr, dp_data, exp_dump[3]); end
                end
            end
            dp_ready = 1'b1;
            @(negedge clk); dp_ready = 1'b0; #1;
            total++;
            if (dp_valid !== 1'b0) begin bad++; $display("FAIL drop%0d got v=%b want 0", b, dp_valid); end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1)
            begin bad++; $display("FAIL done got done=%b busy=%b rst=%b want 1 0 1", done, busy, core_rst); end
    endtask

    task automatic test_mid_reset;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h55; ld_last = 1'b1; #1;
        total++;
        if (dc_we !== 4'hF || dc_a !== 0) begin bad++; $display("FAIL one_word got we=%h a=%h want F 0", dc_we, dc_a); end
        @(negedge clk); ld_data = 32'h77; ld_last = 1'b0; #1;
        total++;
        if (ic_we !== 4'hF || ic_a !== 0 || dc_we !== 0) begin bad++; $display("FAIL after_one got iwe=%h ia=%h dwe=%h want F 0 0", ic_we, ic_a, dc_we); end
        @(negedge clk); rst = 1'b1; #1;
        total++;
        if (ld_ready !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b0 || ic_we !== 0 || dc_we !== 0)
            begin bad++; $display("FAIL mid_rst got rdy=%b rst=%b busy=%b we=%h/%h want 0 1 0 0/0", ld_ready, core_rst, busy, dc_we, ic_we); end
        @(negedge clk); rst = 1'b0; start = 1'b1; ld_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_data = 32'(i); #1;
            total++;
            if (dc_we !== 4'hF || dc_a !== 32'(i * 4)) begin bad++; $display("FAIL reload%0d got we=%h a=%h want F %h", i, dc_we, dc_a, i * 4); end
            @(negedge clk);
        end
        #1;
        total++;
        if (ic_we !== 4'hF || ic_a !== 0 || dc_we !== 0) begin bad++; $display("FAIL full_image got iwe=%h ia=%h dwe=%h want F 0 0", ic_we, ic_a, dc_we); end
        ld_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_run();
        test_dump();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
